// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_ACCESS = 1'b1} arb_state_t;

  typedef enum logic [1:0] {
    UNIT_BYTE = 2'd0,
    UNIT_HALF = 2'd1,
    UNIT_WORD = 2'd2
  } mem_unit_t;

  localparam int MAX_MASTERS = 8;

  // Successor of idx, wrapping back to lo once it reaches n.
  function automatic int rr_next(input int idx, input int lo, input int n);
    return ((idx + 1) >= n) ? lo : (idx + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping.
// With MEM_ARB_PRIO0_EN defined, req[0] always wins and rotation covers 1..N-1.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the pointer; only the first hit is kept.
  always_comb begin
    int   cand;
    int   base;
    logic hit;
    valid = 1'b0;
    idx   = {IW{1'b0}};
    cand  = 0;
    base  = 0;
    hit   = 1'b0;
`ifdef MEM_ARB_PRIO0_EN
    base = (int'(ptr) < 1) ? 1 : int'(ptr);
    for (int off = 0; off < N - 1; off++) begin
      cand  = 1 + ((base - 1 + off) % (N - 1));
      hit   = !valid && req[cand];
      valid = valid | hit;
      idx   = hit ? cand[IW-1:0] : idx;
    end
    idx   = req[0] ? {IW{1'b0}} : idx;
    valid = valid | req[0];
`else
    base = int'(ptr);
    for (int off = 0; off < N; off++) begin
      cand  = (base + off) % N;
      hit   = !valid && req[cand];
      valid = valid | hit;
      idx   = hit ? cand[IW-1:0] : idx;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the mmu's single memory port among NUM_MASTERS.
// Optional MEM_ARB_PRIO0_EN gives master 0 absolute priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_MASTERS   = 2,
  parameter int  ACCESS_CYCLES = 1,
  localparam int IW            = $clog2(NUM_MASTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MASTERS-1:0]      m_req,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [NUM_MASTERS-1:0][1:0] m_unit,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr,
  input  logic [NUM_MASTERS-1:0][31:0] m_wd,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [31:0]                 m_rd,
  output logic [1:0]                  m_fault,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [1:0]                  mem_rd_unit,
  output logic [1:0]                  mem_wd_unit,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wd,
  input  logic [31:0]                 mem_rd,
  input  logic                        access_fault,
  input  logic                        addr_misaligned,
  output logic [IW-1:0]               grant_idx
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
    $error("mem_bus_arbiter: NUM_MASTERS out of range");
  end

  localparam logic [3:0] AC_LAST = 4'(ACCESS_CYCLES - 1);

  arb_state_t           state_r;
  arb_state_t           state_nxt_s;
  logic [3:0]           cnt_r;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        ptr_nxt_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 pick_valid_s;
  logic                 done_s;
  logic [NUM_MASTERS-1:0] ack_nxt_s;

  rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req   (m_req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ARB_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next state and completion strobe
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) state_nxt_s = ARB_ACCESS;
        else              state_nxt_s = ARB_IDLE;
      end
      ARB_ACCESS: begin
        if (cnt_r == AC_LAST) begin
          done_s      = 1'b1;
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_ACCESS;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // Pointer advance and per-master ack decode
  always_comb begin
`ifdef MEM_ARB_PRIO0_EN
    // A priority win by master 0 must not disturb the rotation of the others.
    if (grant_idx == {IW{1'b0}}) ptr_nxt_s = ptr_r;
    else ptr_nxt_s = IW'(rr_next(int'(grant_idx), 1, NUM_MASTERS));
`else
    ptr_nxt_s = IW'(rr_next(int'(grant_idx), 0, NUM_MASTERS));
`endif
    for (int i = 0; i < NUM_MASTERS; i++) begin
      ack_nxt_s[i] = done_s && (grant_idx == IW'(i));
    end
  end

  // Counter, owner, pointer and completion capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= 4'd0;
      ptr_r     <= {IW{1'b0}};
      grant_idx <= {IW{1'b0}};
      m_ack     <= {NUM_MASTERS{1'b0}};
      m_rd      <= 32'd0;
      m_fault   <= 2'b00;
    end else begin
      m_ack <= ack_nxt_s;
      if (state_r == ARB_IDLE) begin
        cnt_r <= 4'd0;
        if (pick_valid_s) grant_idx <= pick_idx_s;
      end else begin
        cnt_r <= cnt_r + 4'd1;
        if (done_s) begin
          m_rd    <= mem_rd;
          m_fault <= {addr_misaligned, access_fault};
          ptr_r   <= ptr_nxt_s;
        end
      end
    end
  end

  // Bus mux: only the owner drives the mmu, and only while in ACCESS
  always_comb begin
    if (state_r == ARB_ACCESS) begin
      mem_re      = ~m_we[grant_idx];
      mem_we      = m_we[grant_idx];
      mem_rd_unit = m_unit[grant_idx];
      mem_wd_unit = m_unit[grant_idx];
      mem_addr    = m_addr[grant_idx];
      mem_wd      = m_wd[grant_idx];
    end else begin
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_rd_unit = 2'b00;
      mem_wd_unit = 2'b00;
      mem_addr    = 32'd0;
      mem_wd      = 32'd0;
    end
  end

endmodule
